safecode_writer: RTL and testbench

Programming front-end for the combination lock: lets the user enter a new button sequence twice, then commits it to a held code register that the lock-checking FSM compares against. It sits beside the checker on the same active-low button bank and the same green/red LED bank, and drives the LEDs only while programming is active (`busy`=1). Power-on code reproduces the factory sequence button0 → button1 → button2.

---
 rtl/safecode_writer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_safecode_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/safecode_writer.sv
// -----------------------------------------------------------------------------
// safecode_writer
//
// Programming front-end for the combination lock. After a rising edge on
// prog_req the user enters a new button sequence, then enters it a second
// time to confirm it. A matching confirmation commits the sequence to the
// held code register that the lock checker compares against. While
// programming is in progress (busy=1) this block owns the shared LED bank,
// and the checker ignores the buttons.
//
// Optional feature macro: SAFECODE_SYNC_EN
//   defined   - btn and prog_req pass through a 2-flop synchronizer before
//               edge detection (+2 cycles of latency).
//   undefined - inputs are assumed synchronous and are sampled directly.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   btn         in   [BTN_W]  raw buttons, active-low (0 = pressed)
//   prog_req    in   programming request, rising-edge sensitive
//   code_out    out  [N_DIGITS*IDX_W] committed code, digit k at [k*IDX_W +: IDX_W]
//   code_update out  one-cycle pulse when code_out changes
//   busy        out  high in every state except IDLE
//   led_green   out  [8] programming status
//   led_red     out  error indication
// -----------------------------------------------------------------------------
module safecode_writer #(
    parameter int unsigned N_DIGITS    = 3,
    parameter int unsigned BTN_W       = 3,
    parameter int unsigned IDX_W       = $clog2(BTN_W),
    parameter logic [N_DIGITS*IDX_W-1:0] DEFAULT_CODE = {2'd2, 2'd1, 2'd0},
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned DONE_CYC    = 250_000_000,
    parameter int unsigned ERR_CYC     = 150_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BTN_W-1:0]          btn,
    input  logic                      prog_req,
    output logic [N_DIGITS*IDX_W-1:0] code_out,
    output logic                      code_update,
    output logic                      busy,
    output logic [7:0]                led_green,
    output logic                      led_red
);

    localparam int unsigned CODE_W  = N_DIGITS * IDX_W;
    localparam int unsigned CNT_W   = $clog2(N_DIGITS + 1);
    localparam int unsigned MAX_AB  = (TIMEOUT_CYC > DONE_CYC) ? TIMEOUT_CYC : DONE_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > ERR_CYC) ? MAX_AB : ERR_CYC;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] TIMEOUT_T = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] DONE_T    = TMR_W'(DONE_CYC);
    localparam logic [TMR_W-1:0] ERR_T     = TMR_W'(ERR_CYC);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_DIGITS - 1);

    typedef enum logic [2:0] {IDLE, ENTER, CONFIRM, DONE, ERROR} state_e;

    // ---------------------------------------------------------------- inputs
    // Synchronizers carry the pressed sense (~btn) so that their reset value
    // of 0 means "nothing pressed".
    logic [BTN_W-1:0] p_in;
    logic             req_in;

`ifdef SAFECODE_SYNC_EN
    logic [BTN_W-1:0] p_s1_q, p_s2_q;
    logic             req_s1_q, req_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_s1_q   <= '0;
            p_s2_q   <= '0;
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
        end else begin
            p_s1_q   <= ~btn;
            p_s2_q   <= p_s1_q;
            req_s1_q <= prog_req;
            req_s2_q <= req_s1_q;
        end
    end

    assign p_in   = p_s2_q;
    assign req_in = req_s2_q;
`else
    assign p_in   = ~btn;
    assign req_in = prog_req;
`endif

    // Sample register plus one-cycle history for edge detection.
    logic [BTN_W-1:0] p_q, p_prev_q;
    logic             req_q, req_prev_q;

    logic [BTN_W-1:0] edge_v;
    logic             multi_press, single_press, req_rise;
    logic [IDX_W-1:0] digit;

    assign edge_v       = p_q & ~p_prev_q;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_press  = |(edge_v & (edge_v - 1'b1));
    assign single_press = (|edge_v) && !multi_press;
    assign req_rise     = req_q && !req_prev_q;

    always_comb begin
        digit = '0;
        for (int i = 0; i < int'(BTN_W); i++) begin
            if (edge_v[i]) digit = IDX_W'(i);
        end
    end

    // ------------------------------------------------------------------- FSM
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;
    logic [CODE_W-1:0]  buf_q, buf_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               upd_q, upd_d;
    logic               busy_q, busy_d;
    logic [7:0]         led_green_q, led_green_d;
    logic               led_red_q, led_red_d;
    logic [IDX_W-1:0]   expect_digit;

    // Timer saturates at all-ones instead of wrapping.
    assign timer_inc    = (&timer_q) ? timer_q : timer_q + 1'b1;
    assign expect_digit = buf_q[cnt_q*IDX_W +: IDX_W];

    function automatic logic [7:0] thermo(input logic [CNT_W-1:0] n);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < int'(n)) t[i] = 1'b1;
        end
        return t;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_inc;
        buf_d   = buf_q;
        code_d  = code_q;
        upd_d   = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (req_rise) begin
                    state_d = ENTER;
                    cnt_d   = '0;
                end
            end
            ENTER: begin
                // A press outranks a timeout landing on the same cycle.
                if (multi_press) begin
                    state_d = ERROR;
                    timer_d = '0;
                end else if (single_press) begin
                    buf_d[cnt_q*IDX_W +: IDX_W] = digit;
                    timer_d = '0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = CONFIRM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (timer_inc == TIMEOUT_T) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            CONFIRM: begin
                if (multi_press || (single_press && digit != expect_digit)) begin
                    state_d = ERROR;
                    timer_d = '0;
                end else if (single_press) begin
                    timer_d = '0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        code_d  = buf_q;
                        upd_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (timer_inc == TIMEOUT_T) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            DONE: begin
                if (timer_inc == DONE_T) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            ERROR: begin
                if (timer_inc == ERR_T) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Outputs are decoded from the next state and then registered.
        busy_d      = (state_d != IDLE);
        led_red_d   = (state_d == ERROR);
        led_green_d = 8'h00;
        case (state_d)
            ENTER:   led_green_d = 8'h80 | thermo(cnt_d);
            CONFIRM: led_green_d = 8'hC0 | thermo(cnt_d);
            DONE:    led_green_d = 8'hFF;
            default: led_green_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            p_prev_q    <= '0;
            req_q       <= 1'b0;
            req_prev_q  <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            timer_q     <= '0;
            // NOTE: the entry buffer is only a few bits, so it is reset like
            // any other register; larger memories would normally be left unreset.
            buf_q       <= '0;
            code_q      <= DEFAULT_CODE;
            upd_q       <= 1'b0;
            busy_q      <= 1'b0;
            led_green_q <= 8'h00;
            led_red_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from
            // before this edge, independent of statement order.
            p_q         <= p_in;
            p_prev_q    <= p_q;
            req_q       <= req_in;
            req_prev_q  <= req_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            buf_q       <= buf_d;
            code_q      <= code_d;
            upd_q       <= upd_d;
            busy_q      <= busy_d;
            led_green_q <= led_green_d;
            led_red_q   <= led_red_d;
        end
    end

    assign code_out    = code_q;
    assign code_update = upd_q;
    assign busy        = busy_q;
    assign led_green   = led_green_q;
    assign led_red     = led_red_q;

endmodule

// File: tb/tb_safecode_writer.sv
// -----------------------------------------------------------------------------
// tb_safecode_writer
//
// Directed bench for safecode_writer with shortened display/timeout intervals.
// Expected values are hand-computed. Build with SAFECODE_SYNC_EN defined to
// exercise the synchronized input path; latencies shift by SYNC cycles.
// -----------------------------------------------------------------------------
module tb_safecode_writer;

    localparam int TO_C   = 20;
    localparam int DONE_C = 8;
    localparam int ERR_C  = 6;
`ifdef SAFECODE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    localparam logic [5:0] DEF_CODE = 6'b10_01_00;
    localparam logic [5:0] NEW_CODE = 6'b01_00_10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn = 3'b111;
    logic       prog_req = 1'b0;
    logic [5:0] code_out;
    logic       code_update;
    logic       busy;
    logic [7:0] led_green;
    logic       led_red;

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;

    safecode_writer #(
        .N_DIGITS    (3),
        .BTN_W       (3),
        .TIMEOUT_CYC (TO_C),
        .DONE_CYC    (DONE_C),
        .ERR_CYC     (ERR_C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .prog_req    (prog_req),
        .code_out    (code_out),
        .code_update (code_update),
        .busy        (busy),
        .led_green   (led_green),
        .led_red     (led_red)
    );

    always #5 clk = ~clk;

    // Count commit pulses half a cycle after each edge.
    always @(negedge clk) if (rst_n && code_update) upd_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hold a pattern for one sample, release, and return just after the edge
    // on which the FSM consumes the press.
    task automatic press_raw(input logic [2:0] b);
        btn = b;
        tick();
        btn = 3'b111;
        tick();
        repeat (SYNC) tick();
    endtask

    task automatic press(input int i);
        logic [2:0] b;
        b    = 3'b111;
        b[i] = 1'b0;
        press_raw(b);
    endtask

    task automatic start_prog();
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
        repeat (SYNC) tick();
        check("req_lat_early", busy, 0);
        tick();
        check("req_busy", busy, 1);
        check("enter_led0", led_green, 8'h80);
    endtask

    task automatic wait_err(input string tag);
        repeat (ERR_C - 1) tick();
        check({tag, "_red_hold"}, led_red, 1);
        tick();
        check({tag, "_red_off"}, led_red, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        // Reset and idle
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        check("rst_code", code_out, DEF_CODE);
        check("rst_busy", busy, 0);
        check("rst_green", led_green, 8'h00);
        check("rst_red", led_red, 0);
        check("rst_upd", code_update, 0);

        // Successful program: enter 2,0,1 and confirm 2,0,1
        start_prog();
        btn = 3'b011;
        tick();
        btn = 3'b111;
        repeat (SYNC) tick();
        check("btn_lat_early", led_green, 8'h80);
        tick();
        check("enter_led1", led_green, 8'h81);
        press(0);
        check("enter_led2", led_green, 8'h83);
        press(1);
        check("confirm_led0", led_green, 8'hC0);
        press(2);
        check("confirm_led1", led_green, 8'hC1);
        press(0);
        check("confirm_led2", led_green, 8'hC3);
        press(1);
        check("done_led", led_green, 8'hFF);
        check("commit_code", code_out, NEW_CODE);
        check("commit_pulse", code_update, 1);
        tick();
        check("commit_pulse_end", code_update, 0);
        check("commit_count", upd_seen, 1);
        repeat (DONE_C - 2) tick();
        check("done_hold", led_green, 8'hFF);
        tick();
        check("done_end_led", led_green, 8'h00);
        check("done_end_idle", busy, 0);

        // Confirm mismatch on the second digit
        start_prog();
        press(2); press(0); press(1);
        press(2);
        press(1);
        check("mis_red", led_red, 1);
        check("mis_green", led_green, 8'h00);
        check("mis_busy", busy, 1);
        wait_err("mis");
        check("mis_code", code_out, NEW_CODE);

        // Multi-press in ENTER (buttons 0 and 1 together)
        start_prog();
        press_raw(3'b100);
        check("multi_red", led_red, 1);
        wait_err("multi");
        check("multi_code", code_out, NEW_CODE);

        // Multi-press on the final CONFIRM digit
        start_prog();
        press(0); press(1); press(2);
        press(0); press(1);
        press_raw(3'b100);
        check("last_multi_red", led_red, 1);
        wait_err("last_multi");
        check("last_multi_code", code_out, NEW_CODE);
        check("last_multi_count", upd_seen, 1);

        // Silent timeout after one digit
        start_prog();
        press(0);
        check("to_led", led_green, 8'h81);
        repeat (TO_C - 1) tick();
        check("to_hold", busy, 1);
        tick();
        check("to_idle", busy, 0);
        check("to_red", led_red, 0);
        check("to_code", code_out, NEW_CODE);

        // Press on the timeout terminal cycle wins and restarts the timer
        start_prog();
        press(0);
        repeat (18 - SYNC) tick();
        press(1);
        check("to_race_led", led_green, 8'h83);
        repeat (TO_C - 1) tick();
        check("to_race_hold", busy, 1);
        tick();
        check("to_race_idle", busy, 0);
        check("to_race_red", led_red, 0);

        // Reset during CONFIRM after a commit reverts to the factory code
        start_prog();
        press(0); press(2); press(2);
        press(0);
        check("pre_rst_led", led_green, 8'hC1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_code", code_out, DEF_CODE);
        check("mid_rst_green", led_green, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_code", code_out, DEF_CODE);
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
